// File: rtl/store_pkg.sv
// Shared definitions for the store path: funct3 encodings, FSM states and
// the byte-size decode used by both the control and the lane merger.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    MERGE,
    WRITE,
    DONE
  } state_t;

  // Number of bytes written by a store; 0 marks an encoding that is not a store.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] sz;
    case (funct3)
      F3_SB:   sz = 4'd1;
      F3_SH:   sz = 4'd2;
      F3_SW:   sz = 4'd4;
      F3_SD:   sz = 4'd8;
      default: sz = 4'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merger: overwrites `size` bytes of the old memory
// word, starting at byte `offset`, with the low bytes of the new data.
// Bytes outside that window pass through untouched; nothing is sign-extended.
module store_lane_merge #(
  parameter int DATA_W = 64,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [3:0]        size,
  output logic [DATA_W-1:0] merged
);

  // Select, per byte lane, either the old byte or the shifted new byte.
  always_comb begin
    // NOTE: assign the whole output before the conditional updates so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(offset) && i < int'(offset) + int'(size)) begin
        merged[i*8 +: 8] = new_data[(i - int'(offset))*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store path for the multicycle core. Full-width stores go straight to a
// write; narrower stores read the containing word, merge the new bytes at
// their offset and write the word back. Misaligned or invalid stores are
// rejected without touching memory.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              misaligned
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t state, state_next;

  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mis_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        req_size;
  logic              illegal;
  logic              full;
  logic [DATA_W-1:0] merged;

  // Classify the incoming request: invalid encoding, too wide, or misaligned.
  always_comb begin
    req_size = size_bytes(req_funct3);
    illegal  = 1'b0;
    if (req_size == 4'd0) begin
      illegal = 1'b1;
    end else if (int'(req_size) > NB) begin
      illegal = 1'b1;
    end else if ((req_addr[2:0] & 3'(req_size - 4'd1)) != 3'd0) begin
      illegal = 1'b1;
    end
    full = (int'(req_size) == NB);
  end

  store_lane_merge #(
    .DATA_W (DATA_W)
  ) u_lane_merge (
    .old_word (rdata_q),
    .new_data (data_q),
    .offset   (addr_q[OFF_W-1:0]),
    .size     (size_bytes(funct3_q)),
    .merged   (merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (illegal)   state_next = DONE;
          else if (full) state_next = WRITE;
          else           state_next = READ;
        end
      end
      READ: begin
        mem_rd     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_next = MERGE;
      end
      MERGE: state_next = WRITE;
      WRITE: begin
        // A reset arriving in the write cycle cancels the write.
        mem_wr     = ~reset;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        misaligned = mis_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches, read-latency counter, captured read word and write word.
  always_ff @(posedge clk) begin
    // NOTE: the data latches are reset too, so mem_addr and mem_wdata read
    // as zero after reset rather than showing stale or unknown values.
    if (reset) begin
      funct3_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            data_q   <= req_data;
            wdata_q  <= req_data;
            mis_q    <= illegal;
          end
        end
        READ: cnt_q <= CNT_W'(RD_LAT);
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) rdata_q <= mem_rdata;
        end
        MERGE: wdata_q <= merged;
        default: ;
      endcase
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit (DATA_W=64, RD_LAT=2): directed
// vector table, reset-abort and back-to-back sequences, then random stores
// against a byte-mask reference model and a fixed-latency memory model.
module tb_store_merge_unit;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              misaligned;

  store_merge_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  typedef struct {
    int   cyc;
    logic mis;
  } done_t;

  ev_t   rd_q[$];
  ev_t   wr_q[$];
  done_t done_q[$];
  bit    ready_at[int];

  logic [63:0] mem [logic [63:0]];
  int          rd_cyc   = 0;
  logic [63:0] rd_addr  = '0;
  bit          rd_armed = 1'b0;

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h9E37_79B9, ~a[31:0]};
  endfunction

  // Observe the DUT mid-cycle, act as memory: data valid only RD_LAT cycles after the strobe.
  always @(negedge clk) begin
    ready_at[cyc] = req_ready;
    if (mem_rd === 1'b1) begin
      rd_q.push_back(ev_t'{cyc, mem_addr, 64'd0});
      rd_cyc   = cyc;
      rd_addr  = mem_addr;
      rd_armed = 1'b1;
    end
    if (mem_wr === 1'b1) begin
      wr_q.push_back(ev_t'{cyc, mem_addr, mem_wdata});
      mem[mem_addr] = mem_wdata;
    end
    if (done === 1'b1) done_q.push_back(done_t'{cyc, misaligned});
    mem_rdata = (rd_armed && cyc == rd_cyc + RD_LAT) ? mem_read(rd_addr)
                                                     : 64'hA5A5_5A5A_C3C3_3C3C;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: legality from size/alignment rules, merge via byte mask arithmetic.
  function automatic void model(input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] data, output logic mis,
                                output logic [63:0] wdata);
    int          sz;
    int          off;
    logic [63:0] wa;
    logic [63:0] mask;
    sz    = (f3 < 4) ? (1 << f3) : 0;
    wdata = '0;
    if (sz == 0 || sz * 8 > DATA_W) begin
      mis = 1'b1;
    end else begin
      mis = (addr % sz) != 0;
    end
    if (!mis) begin
      wa  = addr & ~64'(DATA_W / 8 - 1);
      off = int'(addr % (DATA_W / 8));
      if (sz * 8 == DATA_W) begin
        wdata = data;
      end else begin
        mask  = ((64'd1 << (8 * sz)) - 64'd1) << (8 * off);
        wdata = (mem_read(wa) & ~mask) | ((data << (8 * off)) & mask);
      end
    end
  endfunction

  // Issue one request and check every memory strobe, its timing and the outcome.
  task automatic run_req(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] data, input logic exp_mis,
                         input logic [63:0] exp_wdata);
    int          t;
    int          i;
    int          dc;
    int          hi;
    int          rd_exp;
    int          wr_lat;
    int          done_lat;
    bit          full;
    logic [63:0] wa;
    wa   = addr & ~64'(DATA_W / 8 - 1);
    full = (f3 < 4) && ((1 << f3) * 8 == DATA_W);
    i = 0;
    while (!req_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check({tag, " ready_idle"}, 64'(req_ready), 64'd1);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    req_funct3 = f3;
    req_addr   = addr;
    req_data   = data;
    req_valid  = 1'b1;
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    i = 0;
    while (done_q.size() == 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);

    if (exp_mis) begin
      rd_exp = 0; wr_lat = 0; done_lat = 1;
    end else if (full) begin
      rd_exp = 0; wr_lat = 1; done_lat = 2;
    end else begin
      rd_exp = 1; wr_lat = RD_LAT + 3; done_lat = RD_LAT + 4;
    end

    check({tag, " done_count"}, 64'(done_q.size()), 64'd1);
    dc = t + 1;
    if (done_q.size() > 0) begin
      dc = done_q[0].cyc;
      check({tag, " done_cycle"}, 64'(dc - t), 64'(done_lat));
      check({tag, " misaligned"}, 64'(done_q[0].mis), 64'(exp_mis));
    end
    check({tag, " rd_count"}, 64'(rd_q.size()), 64'(rd_exp));
    if (rd_q.size() > 0 && rd_exp > 0) begin
      check({tag, " rd_cycle"}, 64'(rd_q[0].cyc - t), 64'd1);
      check({tag, " rd_addr"}, rd_q[0].addr, wa);
    end
    check({tag, " wr_count"}, 64'(wr_q.size()), exp_mis ? 64'd0 : 64'd1);
    if (wr_q.size() > 0 && !exp_mis) begin
      check({tag, " wr_cycle"}, 64'(wr_q[0].cyc - t), 64'(wr_lat));
      check({tag, " wr_addr"}, wr_q[0].addr, wa);
      check({tag, " wr_data"}, wr_q[0].data, exp_wdata);
    end
    hi = 0;
    for (int c = t + 1; c <= dc; c++) if (ready_at.exists(c) && ready_at[c]) hi++;
    check({tag, " ready_low_busy"}, 64'(hi), 64'd0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] mem_word;
    logic [63:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] d;
    logic        mis;
    logic [63:0] wd;
    logic [63:0] base_word;
    base_word = 64'h1122_3344_5566_7788;

    vecs[0] = '{3'd0, 64'h1003, 64'h0000_0000_0000_00AB, base_word, 64'h1122_3344_AB66_7788, 1'b0};
    vecs[1] = '{3'd1, 64'h1006, 64'h0000_0000_FFFF_BEEF, base_word, 64'hBEEF_3344_5566_7788, 1'b0};
    vecs[2] = '{3'd2, 64'h1004, 64'h9999_9999_1234_5678, base_word, 64'h1234_5678_5566_7788, 1'b0};
    vecs[3] = '{3'd3, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D, base_word, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[4] = '{3'd2, 64'h1002, 64'h1234_5678_9ABC_DEF0, base_word, 64'h0, 1'b1};
    vecs[5] = '{3'd5, 64'h1000, 64'h1234_5678_9ABC_DEF0, base_word, 64'h0, 1'b1};
    vecs[6] = '{3'd1, 64'h1001, 64'h0000_0000_0000_1234, base_word, 64'h0, 1'b1};
    vecs[7] = '{3'd3, 64'h2004, 64'h0123_4567_89AB_CDEF, base_word, 64'h0, 1'b1};
    vecs[8] = '{3'd0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFCD, base_word, 64'h1122_3344_5566_77CD, 1'b0};
    vecs[9] = '{3'd0, 64'h1007, 64'h0000_0000_0000_0012, base_word, 64'h1222_3344_5566_7788, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_data   = '0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset mem_rd", 64'(mem_rd), 64'd0);
    check("reset mem_wr", 64'(mem_wr), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset misaligned", 64'(misaligned), 64'd0);
    check("reset mem_addr", mem_addr, 64'd0);
    check("reset mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int k = 0; k < 10; k++) begin
      mem[vecs[k].addr & ~64'h7] = vecs[k].mem_word;
      run_req($sformatf("vec%0d", k), vecs[k].f3, vecs[k].addr, vecs[k].data,
              vecs[k].exp_mis, vecs[k].exp_wdata);
    end

    // Reset while waiting for read data: no write, unit idle, next store fine.
    mem[64'h1000] = base_word;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    req_funct3 = 3'd0;
    req_addr   = 64'h1003;
    req_data   = 64'hAB;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait ready", 64'(req_ready), 64'd1);
    check("rst_wait mem_wr", 64'(mem_wr), 64'd0);
    check("rst_wait done", 64'(done), 64'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_wait wr_count", 64'(wr_q.size()), 64'd0);
    check("rst_wait done_count", 64'(done_q.size()), 64'd0);
    run_req("after_rst", 3'd0, 64'h1003, 64'hAB, 1'b0, 64'h1122_3344_AB66_7788);

    // Back-to-back with req_valid held: second accept only after done.
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    req_funct3 = 3'd3;
    req_addr   = 64'h4000;
    req_data   = 64'h0102_0304_0506_0708;
    req_valid  = 1'b1;
    t = cyc;
    @(negedge clk);
    req_addr = 64'h4008;
    req_data = 64'h1112_1314_1516_1718;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("hold wr_count", 64'(wr_q.size()), 64'd2);
    check("hold done_count", 64'(done_q.size()), 64'd2);
    check("hold ready_t1", 64'(ready_at[t + 1]), 64'd0);
    check("hold ready_t2", 64'(ready_at[t + 2]), 64'd0);
    check("hold ready_t3", 64'(ready_at[t + 3]), 64'd1);
    if (wr_q.size() == 2) begin
      check("hold wr0_cycle", 64'(wr_q[0].cyc - t), 64'd1);
      check("hold wr0_data", wr_q[0].data, 64'h0102_0304_0506_0708);
      check("hold wr1_cycle", 64'(wr_q[1].cyc - t), 64'd4);
      check("hold wr1_addr", wr_q[1].addr, 64'h4008);
      check("hold wr1_data", wr_q[1].data, 64'h1112_1314_1516_1718);
    end
    if (done_q.size() == 2) check("hold done1_cycle", 64'(done_q[1].cyc - t), 64'd5);

    // Random stores against the reference model.
    for (int k = 0; k < 60; k++) begin
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a  = 64'h3000 + 64'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      model(f3, a, d, mis, wd);
      run_req($sformatf("rnd%0d", k), f3, a, d, mis, wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
